// File: rtl/instruction_fetch_stage_if.sv
// Control/data bundle between the fetch stage and its surroundings (pipeline control, loader, debug).
// IF_PERF_COUNTERS_EN adds the fetch/flush counter outputs.
interface instruction_fetch_stage_if #(
  parameter int NB        = 32,
  parameter int TAM_INSTR = 64
);
  localparam int IDX_W = $clog2(TAM_INSTR);

  logic             i_step;
  logic             i_stall;
  logic             i_jump_valid;
  logic [NB-1:0]    i_jump_target;
  logic             i_load_en;
  logic [IDX_W-1:0] i_load_addr;
  logic [NB-1:0]    i_load_data;
  logic [IDX_W-1:0] i_debug_address;
  logic [NB-1:0]    o_pc;
  logic [NB-1:0]    o_instruction;
  logic [NB-1:0]    o_pc_plus4;
  logic             o_valid;
  logic             o_flush_id;
  logic             o_halted;
  logic [NB-1:0]    o_debug_instr;
`ifdef IF_PERF_COUNTERS_EN
  logic [NB-1:0]    o_fetch_count;
  logic [NB-1:0]    o_flush_count;

  modport master (
    output i_step, i_stall, i_jump_valid, i_jump_target,
    output i_load_en, i_load_addr, i_load_data, i_debug_address,
    input  o_pc, o_instruction, o_pc_plus4, o_valid, o_flush_id, o_halted, o_debug_instr,
    input  o_fetch_count, o_flush_count
  );
  modport slave (
    input  i_step, i_stall, i_jump_valid, i_jump_target,
    input  i_load_en, i_load_addr, i_load_data, i_debug_address,
    output o_pc, o_instruction, o_pc_plus4, o_valid, o_flush_id, o_halted, o_debug_instr,
    output o_fetch_count, o_flush_count
  );
`else
  modport master (
    output i_step, i_stall, i_jump_valid, i_jump_target,
    output i_load_en, i_load_addr, i_load_data, i_debug_address,
    input  o_pc, o_instruction, o_pc_plus4, o_valid, o_flush_id, o_halted, o_debug_instr
  );
  modport slave (
    input  i_step, i_stall, i_jump_valid, i_jump_target,
    input  i_load_en, i_load_addr, i_load_data, i_debug_address,
    output o_pc, o_instruction, o_pc_plus4, o_valid, o_flush_id, o_halted, o_debug_instr
  );
`endif
endinterface

// File: rtl/instruction_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, instruction memory and IF/ID register.
// Optional fetch/flush performance counters are enabled with IF_PERF_COUNTERS_EN.
module instruction_fetch_stage #(
  parameter int NB        = 32,
  parameter int TAM_INSTR = 64
) (
  input logic                      i_clk,
  input logic                      i_reset,
  instruction_fetch_stage_if.slave bus
);
  localparam int         IDX_W       = $clog2(TAM_INSTR);
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  logic [NB-1:0]    imem_r [TAM_INSTR];
  logic [NB-1:0]    pc_r;
  logic [NB-1:0]    instr_r;
  logic [NB-1:0]    pc_plus4_r;
  logic             valid_r;
  logic             halted_r;

  logic [NB-1:0]    pc_next_s;
  logic [NB-1:0]    instr_next_s;
  logic [NB-1:0]    pc_plus4_next_s;
  logic             valid_next_s;
  logic             halted_next_s;
  logic [IDX_W-1:0] fetch_idx_s;
  logic [NB-1:0]    fetch_word_s;
  logic [NB-1:0]    seq_pc_s;
  logic             jump_s;

  function automatic logic is_halt_f(input logic [NB-1:0] word);
    return word[NB-1:NB-6] == HALT_OPCODE;
  endfunction

  // Upper PC bits are ignored, so fetches wrap modulo the memory depth.
  assign fetch_idx_s  = pc_r[IDX_W+1:2];
  assign fetch_word_s = imem_r[fetch_idx_s];
  assign seq_pc_s     = pc_r + NB'(4);
  assign jump_s       = bus.i_step & bus.i_jump_valid;

  // Next-state selection: jump > halted > stall > sequential, all gated by i_step.
  always_comb begin
    pc_next_s       = pc_r;
    instr_next_s    = instr_r;
    pc_plus4_next_s = pc_plus4_r;
    valid_next_s    = valid_r;
    halted_next_s   = halted_r;
    if (!bus.i_step) begin
      pc_next_s = pc_r;
    end else if (bus.i_jump_valid) begin
      // A HALT fetched alongside the jump is wrong-path, so halted is cleared.
      pc_next_s       = {bus.i_jump_target[NB-1:2], 2'b00};
      instr_next_s    = {NB{1'b0}};
      pc_plus4_next_s = {NB{1'b0}};
      valid_next_s    = 1'b0;
      halted_next_s   = 1'b0;
    end else if (halted_r) begin
      pc_next_s = pc_r;
    end else if (bus.i_stall) begin
      pc_next_s = pc_r;
    end else begin
      instr_next_s    = fetch_word_s;
      pc_plus4_next_s = seq_pc_s;
      valid_next_s    = 1'b1;
      if (is_halt_f(fetch_word_s)) begin
        halted_next_s = 1'b1;
        pc_next_s     = pc_r;
      end else begin
        pc_next_s = seq_pc_s;
      end
    end
  end

  // PC, IF/ID and halt flag registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_r       <= {NB{1'b0}};
      instr_r    <= {NB{1'b0}};
      pc_plus4_r <= {NB{1'b0}};
      valid_r    <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      pc_r       <= pc_next_s;
      instr_r    <= instr_next_s;
      pc_plus4_r <= pc_plus4_next_s;
      valid_r    <= valid_next_s;
      halted_r   <= halted_next_s;
    end
  end

  // Debug loader port; contents survive reset and reads in the same cycle see old data.
  always_ff @(posedge i_clk) begin
    if (bus.i_load_en) begin
      imem_r[bus.i_load_addr] <= bus.i_load_data;
    end
  end

  assign bus.o_pc          = pc_r;
  assign bus.o_instruction = instr_r;
  assign bus.o_pc_plus4    = pc_plus4_r;
  assign bus.o_valid       = valid_r;
  assign bus.o_halted      = halted_r;
  assign bus.o_flush_id    = jump_s;
  assign bus.o_debug_instr = imem_r[bus.i_debug_address];

`ifdef IF_PERF_COUNTERS_EN
  logic [NB-1:0] fetch_count_r;
  logic [NB-1:0] flush_count_r;
  logic          seq_fetch_s;

  assign seq_fetch_s = bus.i_step & ~bus.i_jump_valid & ~halted_r & ~bus.i_stall;

  // Free-running wrap-around counters of sequential fetches and applied jumps.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fetch_count_r <= {NB{1'b0}};
      flush_count_r <= {NB{1'b0}};
    end else begin
      fetch_count_r <= fetch_count_r + NB'(seq_fetch_s);
      flush_count_r <= flush_count_r + NB'(jump_s);
    end
  end

  assign bus.o_fetch_count = fetch_count_r;
  assign bus.o_flush_count = flush_count_r;
`endif
endmodule
